// File: rtl/cronometro_mmss_bcd_if.sv
//-----------------------------------------------------------------------------
// cronometro_mmss_bcd_if
// Control inputs and MM:SS BCD display outputs of the stopwatch.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

interface cronometro_mmss_bcd_if;
    logic       slow_clk_in;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;

    modport master (
        output slow_clk_in, start_stop, clear,
        input  sec_units, sec_tens, min_units, min_tens, running, rollover
    );

    modport slave (
        input  slow_clk_in, start_stop, clear,
        output sec_units, sec_tens, min_units, min_tens, running, rollover
    );
endinterface

`default_nettype wire

// File: rtl/cronometro_mmss_bcd.sv
//-----------------------------------------------------------------------------
// cronometro_mmss_bcd
// MM:SS BCD stopwatch counting rising edges of the divided slow clock.
// Optional start_stop debounce enabled by defining CRONO_DEBOUNCE_EN.
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module cronometro_mmss_bcd #(
    parameter int TICKS_PER_COUNT = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire                   clk,
    input  wire                   Reset,
    cronometro_mmss_bcd_if.slave  crono
);

    if (TICKS_PER_COUNT < 1 || TICKS_PER_COUNT > 255 || DEBOUNCE_CYCLES < 1) begin : g_badParams
        $error("cronometro_mmss_bcd: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] c_PRESC_LAST = 8'(TICKS_PER_COUNT - 1);

    state_t     r_state;
    state_t     w_stateNext;

    logic       r_slowS1, r_slowS2, r_slowPrev;
    logic       w_tick;
    logic       r_ssS1, r_ssS2, r_ssPrev;
    logic       w_ssLevel;
    logic       w_press;

    logic [7:0] r_presc;
    logic       w_inc;

    logic [3:0] r_secUnits, r_secTens, r_minUnits, r_minTens;
    logic [3:0] w_secUnitsNext, w_secTensNext, w_minUnitsNext, w_minTensNext;
    logic       w_wrap;
    logic       r_rollover;

    // Both the slow clock and the push button are asynchronous to clk
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_slowS1   <= 1'b0;
            r_slowS2   <= 1'b0;
            r_slowPrev <= 1'b0;
            r_ssS1     <= 1'b0;
            r_ssS2     <= 1'b0;
            r_ssPrev   <= 1'b0;
        end else begin
            r_slowS1   <= crono.slow_clk_in;
            r_slowS2   <= r_slowS1;
            r_slowPrev <= r_slowS2;
            r_ssS1     <= crono.start_stop;
            r_ssS2     <= r_ssS1;
            r_ssPrev   <= w_ssLevel;
        end
    end

    assign w_tick = r_slowS2 & ~r_slowPrev;

`ifdef CRONO_DEBOUNCE_EN
    localparam int c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [c_DEB_W-1:0] r_debCnt;
    logic               r_debLevel;

    // The counter tracks consecutive cycles where the input disagrees with the accepted level
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_debCnt   <= '0;
            r_debLevel <= 1'b0;
        end else if (r_ssS2 == r_debLevel) begin
            r_debCnt   <= '0;
        end else if (r_debCnt == c_DEB_LAST) begin
            r_debCnt   <= '0;
            r_debLevel <= r_ssS2;
        end else begin
            r_debCnt   <= r_debCnt + 1'b1;
        end
    end

    assign w_ssLevel = r_debLevel;
`else
    assign w_ssLevel = r_ssS2;
`endif

    assign w_press = w_ssLevel & ~r_ssPrev;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (crono.clear) begin
            w_stateNext = S_IDLE;
        end else if (w_press) begin
            case (r_state)
                S_IDLE:  w_stateNext = S_RUN;
                S_RUN:   w_stateNext = S_PAUSE;
                S_PAUSE: w_stateNext = S_RUN;
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    assign w_inc = (r_state == S_RUN) && w_tick && (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk) begin
        if (Reset || crono.clear) begin
            r_presc <= 8'd0;
        end else if ((r_state == S_RUN) && w_tick) begin
            r_presc <= (r_presc == c_PRESC_LAST) ? 8'd0 : r_presc + 8'd1;
        end
    end

    always_comb begin
        w_secUnitsNext = r_secUnits;
        w_secTensNext  = r_secTens;
        w_minUnitsNext = r_minUnits;
        w_minTensNext  = r_minTens;
        w_wrap         = 1'b0;
        if (r_secUnits != 4'd9) begin
            w_secUnitsNext = r_secUnits + 4'd1;
        end else begin
            w_secUnitsNext = 4'd0;
            if (r_secTens != 4'd5) begin
                w_secTensNext = r_secTens + 4'd1;
            end else begin
                w_secTensNext = 4'd0;
                if (r_minUnits != 4'd9) begin
                    w_minUnitsNext = r_minUnits + 4'd1;
                end else begin
                    w_minUnitsNext = 4'd0;
                    if (r_minTens != 4'd5) begin
                        w_minTensNext = r_minTens + 4'd1;
                    end else begin
                        w_minTensNext = 4'd0;
                        w_wrap        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset || crono.clear) begin
            r_secUnits <= 4'd0;
            r_secTens  <= 4'd0;
            r_minUnits <= 4'd0;
            r_minTens  <= 4'd0;
        end else if (w_inc) begin
            r_secUnits <= w_secUnitsNext;
            r_secTens  <= w_secTensNext;
            r_minUnits <= w_minUnitsNext;
            r_minTens  <= w_minTensNext;
        end
    end

    // A clear landing on the wrap cycle zeroes the count without announcing a rollover
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_inc & w_wrap & ~crono.clear;
        end
    end

    assign crono.sec_units = r_secUnits;
    assign crono.sec_tens  = r_secTens;
    assign crono.min_units = r_minUnits;
    assign crono.min_tens  = r_minTens;
    assign crono.running   = (r_state == S_RUN);
    assign crono.rollover  = r_rollover;

endmodule

`default_nettype wire
